bcd_to_binary: RTL
==================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled each rising edge.
REQ-005 hundreds  input  4  BCD hundreds digit; sampled only when start is accepted.
REQ-006 tens  input  4  BCD tens digit; sampled only when start is accepted.
REQ-007 ones  input  4  BCD ones digit; sampled only when start is accepted.
REQ-008 binary  output  10  converted value, range 0..999.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when a result (or error) is posted.
REQ-011 err  output  1  high when the last accepted request had a digit >9.

Function
REQ-012 States SHALL be IDLE, CONV and DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; start in CONV SHALL be ignored, with no effect on state, operands or outputs.
REQ-014 On acceptance, the block SHALL latch {hundreds,tens,ones} into a 12-bit BCD field, clear a 10-bit result field, clear err, and load step count 0.
REQ-015 Acceptance with any digit >9 SHALL skip CONV: go to DONE with binary=0, err=1, done=1 and busy=0 in the next cycle.
REQ-016 Acceptance with valid digits SHALL go to CONV; busy SHALL be 1 from the cycle after acceptance.
REQ-017 CONV SHALL use reverse double-dabble with exactly one step per clock and no multiplier.
REQ-018 Each step SHALL shift the 22-bit {BCD,result} register right by 1, then subtract 3 from each post-shift BCD nibble whose value is >=8.
REQ-019 CONV SHALL last exactly 10 steps; the 10th step SHALL load binary from the result field and enter DONE.
REQ-020 Timing: start accepted at edge E0, steps at E1..E10. After E10, done=1, busy=0 and binary is valid; done=0 after E11.
REQ-021 Total latency, start edge to done high, SHALL be 10 clocks for valid input and 1 clock for invalid input.
REQ-022 DONE SHALL last one cycle, then go to IDLE unless start is accepted in that cycle. A start in DONE SHALL begin a new conversion immediately, with no idle gap.
REQ-023 binary and err SHALL hold their last posted values until the next posting.
REQ-024 Between acceptance and posting, binary SHALL hold the previous result and SHALL NOT show intermediate values.
REQ-025 busy and done SHALL never be high in the same cycle.
REQ-026 Input digit changes after acceptance SHALL NOT affect the result in progress.

Reset
REQ-027 rst=1 SHALL, asynchronously and at any time including mid-CONV, force state IDLE, binary=0, busy=0, done=0, err=0, and clear the step count and shift register.
REQ-028 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.
REQ-029 An aborted conversion SHALL produce no done pulse.

Verification
REQ-030 Start with {0,0,0} -> done 10 clocks later, binary=0, err=0; busy high for exactly 10 cycles.
REQ-031 Start with {9,9,9} -> binary=999 (0x3E7); start with {1,2,7} -> binary=127; start with {0,5,0} -> binary=50; all with err=0.
REQ-032 Start with {3,10,4} -> done 1 clock later, err=1, binary=0, busy never high; then start with {4,5,6} -> binary=456, err=0.
REQ-033 Start {2,5,5}, then pulse start with {9,9,9} at step 4 -> only one done pulse, binary=255, and the second request is ignored.
REQ-034 Start {8,8,8} and assert rst at step 6 -> all outputs 0 immediately and no done; then start {0,4,2} -> binary=42.
REQ-035 Back-to-back requests: hold start=1 with {1,0,0} then {0,0,1} presented in the done cycle -> done pulses 11 clocks apart, binary=100 then 1.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Sequential 3-digit BCD to 10-bit binary converter using reverse double-dabble.
// One shift/correct step per clock; ten steps per conversion.
module bcd_to_binary (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   output logic [9:0] binary,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t      state_q, state_d;
   logic [21:0] shift_q, shift_d;
   logic [3:0]  step_q, step_d;
   logic [9:0]  binary_q, binary_d;
   logic        err_q, err_d;

   logic        accept;
   logic        digit_err;
   logic        last_step;
   logic [21:0] shifted;
   logic [21:0] stepped;

   assign accept    = start && (state_q != CONV);
   assign digit_err = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
   assign last_step = (step_q == 4'd9);

   // One reverse double-dabble step: shift right, then pull each BCD nibble
   // that now reads 8 or more back down by 3.
   always_comb begin
      shifted = {1'b0, shift_q[21:1]};
      stepped = shifted;
      for (int i = 0; i < 3; i++) begin
         if (shifted[10 + 4*i + 3]) begin
            stepped[10 + 4*i +: 4] = shifted[10 + 4*i +: 4] - 4'd3;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = digit_err ? DONE : CONV;
            end else begin
               state_d = IDLE;
            end
         end
         CONV: begin
            if (last_step) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Invalid digits post an error result straight away; binary only ever
   // changes at a posting so intermediate values are never visible.
   always_comb begin
      shift_d  = shift_q;
      step_d   = step_q;
      binary_d = binary_q;
      err_d    = err_q;
      if (accept) begin
         shift_d = {hundreds, tens, ones, 10'd0};
         step_d  = 4'd0;
         err_d   = digit_err;
         if (digit_err) begin
            binary_d = 10'd0;
         end
      end else if (state_q == CONV) begin
         shift_d = stepped;
         step_d  = step_q + 4'd1;
         if (last_step) begin
            binary_d = stepped[9:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q  <= 22'd0;
         step_q   <= 4'd0;
         binary_q <= 10'd0;
         err_q    <= 1'b0;
      end else begin
         shift_q  <= shift_d;
         step_q   <= step_d;
         binary_q <= binary_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      busy   = (state_q == CONV);
      done   = (state_q == DONE);
      binary = binary_q;
      err    = err_q;
   end

endmodule
